// File: rtl/magnitude_comparator.sv
// Registered WIDTH-bit magnitude comparator with 7485-style cascade inputs.
// Define MAGCMP_SIGNED_EN to compare a/b as two's-complement instead of unsigned.
module magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             gi,
    input  logic             eqi,
    input  logic             li,
    output logic             g,
    output logic             eq,
    output logic             l,
    output logic             out_valid
);

    logic a_gt;
    logic a_lt;
    logic g_reg, g_next;
    logic eq_reg, eq_next;
    logic l_reg, l_next;
    logic out_valid_reg, out_valid_next;

`ifdef MAGCMP_SIGNED_EN
    always_comb begin
        a_gt = $signed(a) > $signed(b);
        a_lt = $signed(a) < $signed(b);
    end
`else
    always_comb begin
        a_gt = a > b;
        a_lt = a < b;
    end
`endif

    // On equal operands, resolve from the cascade with priority gi > li > eqi;
    // eqi is implied when neither gi nor li is set, so the result stays one-hot.
    always_comb begin
        g_next         = g_reg;
        eq_next        = eq_reg;
        l_next         = l_reg;
        out_valid_next = 1'b0;
        if (in_valid) begin
            out_valid_next = 1'b1;
            if (a_gt) begin
                g_next  = 1'b1;
                eq_next = 1'b0;
                l_next  = 1'b0;
            end else if (a_lt) begin
                g_next  = 1'b0;
                eq_next = 1'b0;
                l_next  = 1'b1;
            end else if (gi) begin
                g_next  = 1'b1;
                eq_next = 1'b0;
                l_next  = 1'b0;
            end else if (li) begin
                g_next  = 1'b0;
                eq_next = 1'b0;
                l_next  = 1'b1;
            end else begin
                g_next  = 1'b0;
                eq_next = 1'b1;
                l_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_reg         <= 1'b0;
            eq_reg        <= 1'b0;
            l_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            g_reg         <= g_next;
            eq_reg        <= eq_next;
            l_reg         <= l_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign g         = g_reg;
    assign eq        = eq_reg;
    assign l         = l_reg;
    assign out_valid = out_valid_reg;

    // eqi only matters as the fall-through case of the cascade priority.
    logic unused_eqi;
    assign unused_eqi = eqi;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Self-checking bench for magnitude_comparator (WIDTH=4) against an arithmetic model.
// Honours MAGCMP_SIGNED_EN when the bundle is compiled with it.
module tb_magnitude_comparator;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         gi;
    logic         eqi;
    logic         li;
    logic         g;
    logic         eq;
    logic         l;
    logic         out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    magnitude_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .gi(gi), .eqi(eqi), .li(li),
        .g(g), .eq(eq), .l(l), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference ordering as integers; returns {g, eq, l}.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cg, input logic cl);
        int xv;
        int yv;
        xv = int'(x);
        yv = int'(y);
`ifdef MAGCMP_SIGNED_EN
        if (x[W-1]) xv = xv - (1 << W);
        if (y[W-1]) yv = yv - (1 << W);
`endif
        if (xv > yv) return 3'b100;
        if (xv < yv) return 3'b001;
        if (cg)      return 3'b100;
        if (cl)      return 3'b001;
        return 3'b010;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 4'd5; b = 4'd3;
        gi = 1'b0; eqi = 1'b1; li = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if ({g, eq, l, out_valid} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: got g/eq/l/ov=%b, want 0000", i, {g, eq, l, out_valid});
            end
            $display("[TB] reset cycle %0d g/eq/l/ov=%b", i, {g, eq, l, out_valid});
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic [2:0]   exp_f [3];
        av = '{4'd3, 4'd4, 4'd4};
        bv = '{4'd2, 4'd5, 4'd4};
        exp_f = '{3'b100, 3'b001, 3'b010};
        gi = 1'b0; eqi = 1'b1; li = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = av[i]; b = bv[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            tests_run++;
            if ({g, eq, l, out_valid} !== {exp_f[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL basic a=%0d b=%0d: got g/eq/l/ov=%b, want %b",
                         av[i], bv[i], {g, eq, l, out_valid}, {exp_f[i], 1'b1});
            end
            $display("[TB] basic a=%0d b=%0d g/eq/l/ov=%b", av[i], bv[i], {g, eq, l, out_valid});
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic out_valid drop: got %b, want 0", out_valid);
        end
    endtask

    task automatic test_sweep();
        logic [2:0] exp_f;
        int errs;
        errs = 0;
        gi = 1'b0; eqi = 1'b1; li = 1'b0; in_valid = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a = W'(x); b = W'(y);
                exp_f = ref_flags(W'(x), W'(y), 1'b0, 1'b0);
                step();
                tests_run++;
                if ({g, eq, l, out_valid} !== {exp_f, 1'b1} || ($countones({g, eq, l}) != 1)) begin
                    tests_failed++;
                    errs++;
                    $display("FAIL sweep a=%0d b=%0d: got g/eq/l/ov=%b, want %b",
                             x, y, {g, eq, l, out_valid}, {exp_f, 1'b1});
                end
            end
        end
        in_valid = 1'b0;
        $display("[TB] sweep 256 compares, %0d errors", errs);
        step();
    endtask

    task automatic test_cascade();
        logic [2:0] casc [4];
        logic [2:0] exp_f [4];
        // {gi, eqi, li}
        casc  = '{3'b100, 3'b001, 3'b101, 3'b000};
        exp_f = '{3'b100, 3'b001, 3'b100, 3'b010};
        a = 4'd9; b = 4'd9;
        for (int i = 0; i < 4; i++) begin
            {gi, eqi, li} = casc[i];
            in_valid = 1'b1;
            step();
            tests_run++;
            if ({g, eq, l, out_valid} !== {exp_f[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL cascade gi/eqi/li=%b: got g/eq/l/ov=%b, want %b",
                         casc[i], {g, eq, l, out_valid}, {exp_f[i], 1'b1});
            end
            $display("[TB] cascade gi/eqi/li=%b g/eq/l/ov=%b", casc[i], {g, eq, l, out_valid});
        end
        in_valid = 1'b0; gi = 1'b0; eqi = 1'b1; li = 1'b0;
        step();
    endtask

    task automatic test_hold();
        a = 4'd7; b = 4'd1; in_valid = 1'b1;
        step();
        tests_run++;
        if ({g, eq, l, out_valid} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL hold load: got g/eq/l/ov=%b, want 1001", {g, eq, l, out_valid});
        end
        in_valid = 1'b0; a = 4'd0; b = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({g, eq, l, out_valid} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: got g/eq/l/ov=%b, want 1000", i, {g, eq, l, out_valid});
            end
            $display("[TB] hold cycle %0d g/eq/l/ov=%b", i, {g, eq, l, out_valid});
        end
    endtask

    task automatic test_signed();
        logic [2:0] exp_f;
`ifdef MAGCMP_SIGNED_EN
        exp_f = 3'b001;
`else
        exp_f = 3'b100;
`endif
        a = 4'b1000; b = 4'b0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({g, eq, l, out_valid} !== {exp_f, 1'b1}) begin
            tests_failed++;
            $display("FAIL signed 1000 vs 0001: got g/eq/l/ov=%b, want %b",
                     {g, eq, l, out_valid}, {exp_f, 1'b1});
        end
        $display("[TB] signed 1000 vs 0001 g/eq/l/ov=%b", {g, eq, l, out_valid});
        step();
    endtask

    // Random valid gaps, cascade patterns and mid-stream resets against a held-state model.
    task automatic test_random();
        logic [2:0] held;
        logic       exp_ov;
        int errs;
        errs = 0;
        held = {g, eq, l};
        for (int i = 0; i < 400; i++) begin
            a = W'($urandom); b = W'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            {gi, eqi, li} = 3'($urandom);
            in_valid = 1'($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 39) == 0);
            if (rst) begin
                held = 3'b000; exp_ov = 1'b0;
            end else if (in_valid) begin
                held = ref_flags(a, b, gi, li); exp_ov = 1'b1;
            end else begin
                exp_ov = 1'b0;
            end
            step();
            tests_run++;
            if ({g, eq, l, out_valid} !== {held, exp_ov}) begin
                tests_failed++;
                errs++;
                $display("FAIL random #%0d a=%0d b=%0d: got g/eq/l/ov=%b, want %b",
                         i, a, b, {g, eq, l, out_valid}, {held, exp_ov});
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        $display("[TB] random 400 cycles, %0d errors", errs);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        gi = 1'b0; eqi = 1'b1; li = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sweep();
        test_cascade();
        test_hold();
        test_signed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
